ripple_count_sampler: RTL

Synchronous sampler that sits directly downstream of the 3-bit asynchronous ripple up-counter. It brings the ripple output into the system clock domain, rejects transient codes produced while the ripple settles, and publishes each accepted count value. It also raises event pulses for new values, wrap-around (max→0) and skipped or backward steps, and keeps a running wrap count for downstream logic.

---
 rtl/ripple_count_sampler_if.sv | 25 ++
 rtl/ripple_count_sampler.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ripple_count_sampler_if.sv
// Bus bundle between the ripple-counter sampler and its consumer.
// master drives the raw count and clear; slave (the sampler) drives the results.
interface ripple_count_sampler_if #(
    parameter int unsigned W = 3
);
    logic [W-1:0] cnt_in;
    logic         clr;
    logic [W-1:0] count_out;
    logic         count_valid;
    logic         new_pulse;
    logic         wrap_pulse;
    logic         skip_err;
    logic [7:0]   wrap_cnt;
    logic [7:0]   err_cnt;

    modport master (
        output cnt_in, clr,
        input  count_out, count_valid, new_pulse, wrap_pulse, skip_err, wrap_cnt, err_cnt
    );

    modport slave (
        input  cnt_in, clr,
        output count_out, count_valid, new_pulse, wrap_pulse, skip_err, wrap_cnt, err_cnt
    );
endinterface

// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple up-counter, filters settling glitches and flags steps.
// Optional: define RIPPLE_SAMPLER_ERRCNT_EN to build the saturating skip-error counter.
module ripple_count_sampler #(
    parameter int unsigned W      = 3,
    parameter int unsigned STABLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    ripple_count_sampler_if.slave  bus
);
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 8;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    sync1, sync2;
    logic [W-1:0]    cand;
    logic [SW-1:0]   stab;

    logic [W-1:0]    count_q, count_d;
    logic            valid_q, valid_d;
    logic            new_q, new_d;
    logic            wrap_q, wrap_d;
    logic            skip_q, skip_d;
    logic [CW-1:0]   wrap_cnt_q;
    logic            wrap_inc_c;

    logic            accept_c;
    logic            seq_c;
    logic            top_c;

    // Two-flop synchronizer followed by the run-length stability filter
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            stab  <= '0;
        end else begin
            sync1 <= bus.cnt_in;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                stab <= SW'(1);
            end else if (stab < SW'(STABLE)) begin
                stab <= stab + SW'(1);
            end
        end
    end

    assign accept_c = (stab == SW'(STABLE)) && ((state_q == INIT) || (cand != count_q));
    assign seq_c    = (cand == (count_q + W'(1)));
    assign top_c    = (count_q == {W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == INIT) && accept_c) state_d = TRACK;
    end

    // Next values of the registered outputs; wrap/skip only judged once tracking
    always_comb begin
        count_d    = count_q;
        valid_d    = (state_d == TRACK);
        new_d      = 1'b0;
        wrap_d     = 1'b0;
        skip_d     = 1'b0;
        wrap_inc_c = 1'b0;
        if (accept_c) begin
            count_d = cand;
            new_d   = 1'b1;
            if (state_q == TRACK) begin
                if (seq_c) begin
                    wrap_d     = top_c;
                    wrap_inc_c = top_c;
                end else begin
                    skip_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            wrap_q  <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            new_q   <= new_d;
            wrap_q  <= wrap_d;
            skip_q  <= skip_d;
        end
    end

    // clr wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || bus.clr)  wrap_cnt_q <= '0;
        else if (wrap_inc_c) wrap_cnt_q <= wrap_cnt_q + CW'(1);
    end

`ifdef RIPPLE_SAMPLER_ERRCNT_EN
    logic [CW-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || bus.clr)                           err_cnt_q <= '0;
        else if (skip_d && (err_cnt_q != {CW{1'b1}})) err_cnt_q <= err_cnt_q + CW'(1);
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

    assign bus.count_out   = count_q;
    assign bus.count_valid = valid_q;
    assign bus.new_pulse   = new_q;
    assign bus.wrap_pulse  = wrap_q;
    assign bus.skip_err    = skip_q;
    assign bus.wrap_cnt    = wrap_cnt_q;
endmodule
